// File: rtl/out_channel_checker.sv
// Out-channel checker: compares a stream of accepted words against a loaded
// expected table, reporting pass, mismatch, timeout or overrun.
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 2,
    parameter int Timeout            = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load,
    input  logic [3:0]                    loadIndex,
    input  logic [MemoryElementWidth-1:0] loadValue,
    input  logic                          start,
    input  logic                          outValid,
    input  logic [MemoryElementWidth-1:0] outData,
    output logic                          outReady,
    output logic                          finished,
    output logic                          success,
    output logic [4:0]                    received,
    output logic [1:0]                    failCode,
    output logic [4:0]                    failIndex
);

    localparam int IdleW = $clog2(Timeout + 1);

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_OVERRUN  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        PASS,
        FAIL
    } state_t;

    state_t                        state_q, state_d;
    logic                          finished_q, finished_d;
    logic                          success_q, success_d;
    logic [4:0]                    received_q, received_d;
    logic [1:0]                    fail_code_q, fail_code_d;
    logic [4:0]                    fail_index_q, fail_index_d;
    logic [IdleW-1:0]              idle_q, idle_d;
    logic [MemoryElementWidth-1:0] expected_q [16];

    logic                          xfer;
    logic [IdleW-1:0]              idle_inc;
    logic [4:0]                    received_inc;
    logic [MemoryElementWidth-1:0] cur_expected;

    assign outReady     = (state_q != IDLE);
    assign xfer         = outValid && outReady;
    assign idle_inc     = idle_q + 1'b1;
    assign received_inc = received_q + 5'd1;
    assign cur_expected = expected_q[received_q[3:0]];

    // The table has no reset; its contents are only meaningful after a reload.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && load && ({1'b0, loadIndex} < 5'(NOut))) begin
            expected_q[loadIndex] <= loadValue;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            finished_q   <= 1'b0;
            success_q    <= 1'b0;
            received_q   <= '0;
            fail_code_q  <= FC_NONE;
            fail_index_q <= '0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            finished_q   <= finished_d;
            success_q    <= success_d;
            received_q   <= received_d;
            fail_code_q  <= fail_code_d;
            fail_index_q <= fail_index_d;
            idle_q       <= idle_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        finished_d   = finished_q;
        success_d    = success_q;
        received_d   = received_q;
        fail_code_d  = fail_code_q;
        fail_index_d = fail_index_q;
        idle_d       = idle_q;

        if (start && state_q != CHECK) begin
            state_d      = CHECK;
            finished_d   = 1'b0;
            success_d    = 1'b0;
            received_d   = '0;
            fail_code_d  = FC_NONE;
            fail_index_d = '0;
            idle_d       = '0;
        end else begin
            case (state_q)
                CHECK: begin
                    if (xfer) begin
                        idle_d     = '0;
                        received_d = received_inc;
                        if (outData == cur_expected) begin
                            if (received_inc == 5'(NOut)) begin
                                state_d    = PASS;
                                finished_d = 1'b1;
                                success_d  = 1'b1;
                            end
                        end else begin
                            state_d      = FAIL;
                            finished_d   = 1'b1;
                            success_d    = 1'b0;
                            fail_code_d  = FC_MISMATCH;
                            fail_index_d = received_q;
                        end
                    end else begin
                        idle_d = idle_inc;
                        if (idle_inc == IdleW'(Timeout)) begin
                            state_d      = FAIL;
                            finished_d   = 1'b1;
                            success_d    = 1'b0;
                            fail_code_d  = FC_TIMEOUT;
                            fail_index_d = received_q;
                        end
                    end
                end
                PASS: begin
                    if (xfer) begin
                        state_d      = FAIL;
                        success_d    = 1'b0;
                        fail_code_d  = FC_OVERRUN;
                        fail_index_d = 5'(NOut);
                    end
                end
                default: ;
            endcase
        end
    end

    assign finished  = finished_q;
    assign success   = success_q;
    assign received  = received_q;
    assign failCode  = fail_code_q;
    assign failIndex = fail_index_q;

endmodule
